// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the write- and read-side controllers of the async
// sample FIFO.
//   FIFO_ADDR_WIDTH  : default RAM address width (depth = 2**FIFO_ADDR_WIDTH)
//   FIFO_ALMOST_FULL : default almost-full threshold
//   bin2gray/gray2bin: code conversions. Operands are zero-extended to
//                      CODE_W bits, so they give the right answer for any
//                      pointer width up to CODE_W. Callers size-cast the
//                      result back to their pointer width.
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH  = 4;
    localparam int FIFO_ALMOST_FULL = 12;
    localparam int CODE_W           = 32;

    function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Prefix XOR from the MSB down. Zero upper bits leave the result unchanged.
    function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] gray);
        logic [CODE_W-1:0] bin;
        bin[CODE_W-1] = gray[CODE_W-1];
        for (int i = CODE_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for a Gray-coded bus crossing into the Clk domain.
// It is kept as its own module so that false-path and max-delay constraints
// can target it by name.
//   Clk     : destination clock
//   Reset_n : asynchronous active-low reset, clears both stages
//   d       : asynchronous input bus (must change at most one bit at a time)
//   q       : synchronized output, two Clk edges after d
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl
// Write-side pointer and flag controller for the async sample FIFO.
//   Clk, Reset_n     : write clock, asynchronous active-low reset
//   WrReq_in         : write request this cycle
//   RdPtrGray_in     : read pointer (Gray), from the read clock domain
//   WrEn_out         : RAM write strobe, WrReq_in & ~Full_out
//   WrAddr_out       : RAM write address (low bits of the binary pointer)
//   WrPtrGray_out    : registered Gray write pointer, to the read domain
//   Full_out         : registered full flag
//   AlmostFull_out   : registered, level >= ALMOST_FULL_LEVEL
//   Level_out        : registered fill level, 0..2**ADDR_WIDTH
//   Overflow_out     : sticky, set by a write attempted while full
//   OverflowClr_in   : synchronous clear for Overflow_out (set has priority)
// The read pointer is used only after two synchronizer flops. The flags and
// the level are therefore pessimistic. They lag reads by the sync delay.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH        = FIFO_ADDR_WIDTH,
    parameter int ALMOST_FULL_LEVEL = FIFO_ALMOST_FULL
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  WrReq_in,
    input  logic [ADDR_WIDTH:0]   RdPtrGray_in,
    output logic                  WrEn_out,
    output logic [ADDR_WIDTH-1:0] WrAddr_out,
    output logic [ADDR_WIDTH:0]   WrPtrGray_out,
    output logic                  Full_out,
    output logic                  AlmostFull_out,
    output logic [ADDR_WIDTH:0]   Level_out,
    output logic                  Overflow_out,
    input  logic                  OverflowClr_in
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AF_LEVEL  = PW'(ALMOST_FULL_LEVEL);
    // The write pointer equals the read pointer with the top two Gray bits
    // inverted exactly when the write side is one full lap ahead.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

    logic [PW-1:0] bin_q;
    logic [PW-1:0] gray_q;
    logic [PW-1:0] level_q;
    logic          full_q;
    logic          af_q;
    logic          ovf_q;

    logic [PW-1:0] rq2;
    logic [PW-1:0] bin_next;
    logic [PW-1:0] gray_next;
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] level_next;
    logic          accept;
    logic          full_next;
    logic          af_next;

    sync_2ff #(.WIDTH(PW)) u_rd_sync (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .d       (RdPtrGray_in),
        .q       (rq2)
    );

    always_comb begin
        accept     = WrReq_in & ~full_q;
        bin_next   = bin_q + PW'(accept);
        gray_next  = PW'(bin2gray(CODE_W'(bin_next)));
        rd_bin     = PW'(gray2bin(CODE_W'(rq2)));
        // The subtraction wraps modulo 2**PW, so it is correct across the pointer wrap.
        level_next = bin_next - rd_bin;
        full_next  = (gray_next == (rq2 ^ FULL_MASK));
        af_next    = (level_next >= AF_LEVEL);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bin_q   <= '0;
            gray_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            bin_q   <= bin_next;
            gray_q  <= gray_next;
            level_q <= level_next;
            full_q  <= full_next;
            af_q    <= af_next;
            if (WrReq_in && full_q) begin
                ovf_q <= 1'b1;
            end else if (OverflowClr_in) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign WrEn_out       = accept;
    assign WrAddr_out     = bin_q[ADDR_WIDTH-1:0];
    assign WrPtrGray_out  = gray_q;
    assign Full_out       = full_q;
    assign AlmostFull_out = af_q;
    assign Level_out      = level_q;
    assign Overflow_out   = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl
// Directed bench for fifo_wr_ctrl (ADDR_WIDTH=4, ALMOST_FULL_LEVEL=12).
// A count-based reference model (writes accepted and a delayed copy of the
// read count) predicts every registered output. The predictions go into
// exp_q when a step is driven. They are popped and compared after the edge.
module tb_fifo_wr_ctrl;

    logic       Clk;
    logic       Reset_n;
    logic       WrReq_in;
    logic [4:0] RdPtrGray_in;
    logic       WrEn_out;
    logic [3:0] WrAddr_out;
    logic [4:0] WrPtrGray_out;
    logic       Full_out;
    logic       AlmostFull_out;
    logic [4:0] Level_out;
    logic       Overflow_out;
    logic       OverflowClr_in;

    fifo_wr_ctrl #(.ADDR_WIDTH(4), .ALMOST_FULL_LEVEL(12)) dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .WrReq_in       (WrReq_in),
        .RdPtrGray_in   (RdPtrGray_in),
        .WrEn_out       (WrEn_out),
        .WrAddr_out     (WrAddr_out),
        .WrPtrGray_out  (WrPtrGray_out),
        .Full_out       (Full_out),
        .AlmostFull_out (AlmostFull_out),
        .Level_out      (Level_out),
        .Overflow_out   (Overflow_out),
        .OverflowClr_in (OverflowClr_in)
    );

    // ---------------- clock ----------------
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // ---------------- model state ----------------
    int n_vec = 0;
    int n_err = 0;
    int wr_cnt;      // total accepted writes
    int rd_s1;       // read count seen by first sync stage
    int rd_s2;       // read count seen by second sync stage
    logic m_full;
    logic m_af;
    logic m_ovf;
    // {addr[3:0], gray[4:0], level[4:0], full, af, ovf}
    logic [16:0] exp_q[$];

    function automatic logic [4:0] to_gray(input int cnt);
        logic [4:0] b;
        b = cnt[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        wr_cnt = 0;
        rd_s1  = 0;
        rd_s2  = 0;
        m_full = 1'b0;
        m_af   = 1'b0;
        m_ovf  = 1'b0;
        exp_q.delete();
    endtask

    // Called at posedge+1. Drives one cycle, predicts, clocks, compares.
    task automatic step(input logic wr, input logic clr, input int rd);
        logic        acc;
        int          lvl;
        logic [4:0]  g_prev;
        logic [16:0] e;
        WrReq_in       = wr;
        OverflowClr_in = clr;
        RdPtrGray_in   = to_gray(rd);
        acc = wr && !m_full;
        #1;
        chk("wr_en", 32'(WrEn_out), 32'(acc));
        if (acc) wr_cnt++;
        lvl = wr_cnt - rd_s2;
        if (wr && m_full) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_full = (lvl == 16);
        m_af   = (lvl >= 12);
        rd_s2  = rd_s1;
        rd_s1  = rd;
        exp_q.push_back({4'(wr_cnt), to_gray(wr_cnt), 5'(lvl), m_full, m_af, m_ovf});
        g_prev = WrPtrGray_out;
        @(posedge Clk);
        #1;
        e = exp_q.pop_front();
        chk("wr_addr",  32'(WrAddr_out),     32'(e[16:13]));
        chk("wr_gray",  32'(WrPtrGray_out),  32'(e[12:8]));
        chk("level",    32'(Level_out),      32'(e[7:3]));
        chk("full",     32'(Full_out),       32'(e[2]));
        chk("afull",    32'(AlmostFull_out), 32'(e[1]));
        chk("overflow", 32'(Overflow_out),   32'(e[0]));
        if (acc) chk("gray_one_bit", 32'($countones(WrPtrGray_out ^ g_prev)), 32'd1);
        else     chk("gray_hold",    32'(WrPtrGray_out), 32'(g_prev));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"},  32'(WrAddr_out),     32'd0);
        chk({tag, "_gray"},  32'(WrPtrGray_out),  32'd0);
        chk({tag, "_full"},  32'(Full_out),       32'd0);
        chk({tag, "_afull"}, 32'(AlmostFull_out), 32'd0);
        chk({tag, "_level"}, 32'(Level_out),      32'd0);
        chk({tag, "_ovf"},   32'(Overflow_out),   32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    int   rd_ptr;
    logic r;

    initial begin
        Reset_n        = 1'b0;
        WrReq_in       = 1'b0;
        OverflowClr_in = 1'b0;
        RdPtrGray_in   = 5'd0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        chk_all_zero("por");
        Reset_n = 1'b1;

        // some random traffic, then a reset in the middle of a cycle
        step(1'b1, 1'b0, 0);
        for (int i = 0; i < 5; i++) step(1'($urandom_range(0, 1)), 1'b0, 0);
        #3;
        r              = 1'($urandom_range(0, 1));
        WrReq_in       = r;
        OverflowClr_in = 1'($urandom_range(0, 1));
        RdPtrGray_in   = 5'($urandom_range(0, 31));
        Reset_n        = 1'b0;
        #1;
        chk_all_zero("rst");
        chk("rst_wr_en", 32'(WrEn_out), 32'(r));
        WrReq_in       = 1'b0;
        OverflowClr_in = 1'b0;
        RdPtrGray_in   = 5'd0;
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        model_reset();
        chk("rel_addr", 32'(WrAddr_out), 32'd0);
        chk("rel_gray", 32'(WrPtrGray_out), 32'd0);

        // fill from empty
        for (int i = 0; i < 16; i++) begin
            chk("fill_addr_pre", 32'(WrAddr_out), 32'(i));
            step(1'b1, 1'b0, 0);
            if (i == 10) chk("afull_at_11", 32'(AlmostFull_out), 32'd0);
            if (i == 11) chk("afull_at_12", 32'(AlmostFull_out), 32'd1);
        end
        chk("fill_full",  32'(Full_out),      32'd1);
        chk("fill_level", 32'(Level_out),     32'd16);
        chk("fill_gray",  32'(WrPtrGray_out), 32'b11000);

        // overflow while full
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0);
        chk("ovf_set",  32'(Overflow_out),  32'd1);
        chk("ovf_gray", 32'(WrPtrGray_out), 32'b11000);
        step(1'b1, 1'b1, 0);
        chk("ovf_set_wins", 32'(Overflow_out), 32'd1);
        step(1'b0, 1'b1, 0);
        chk("ovf_clr", 32'(Overflow_out), 32'd0);

        // read release latency: full drops on the 3rd edge
        step(1'b0, 1'b0, 1);
        chk("rel_edge1_full", 32'(Full_out), 32'd1);
        step(1'b0, 1'b0, 1);
        chk("rel_edge2_full", 32'(Full_out), 32'd1);
        step(1'b0, 1'b0, 1);
        chk("rel_edge3_full",  32'(Full_out),  32'd0);
        chk("rel_edge3_level", 32'(Level_out), 32'd15);
        step(1'b1, 1'b0, 1);
        chk("refill_full",  32'(Full_out),  32'd1);
        chk("refill_level", 32'(Level_out), 32'd16);

        // drain partially, then 40 writes across the pointer wrap
        rd_ptr = 1;
        while (rd_ptr < 13) begin
            rd_ptr++;
            step(1'b0, 1'b0, rd_ptr);
        end
        for (int i = 0; i < 40; i++) begin
            if (rd_ptr < wr_cnt && ((wr_cnt - rd_ptr) >= 5 || $urandom_range(0, 1) == 1))
                rd_ptr++;
            step(1'b1, 1'b0, rd_ptr);
            chk("wrap_no_full", 32'(Full_out), 32'd0);
            chk("wrap_lvl_le8", 32'(Level_out <= 5'd8), 32'd1);
        end

        // simultaneous write and read advance at level 12
        while (wr_cnt - rd_ptr < 12) step(1'b1, 1'b0, rd_ptr);
        step(1'b0, 1'b0, rd_ptr);
        step(1'b0, 1'b0, rd_ptr);
        chk("sim_pre_level", 32'(Level_out), 32'd12);
        step(1'b0, 1'b0, rd_ptr + 1);
        step(1'b0, 1'b0, rd_ptr + 1);
        step(1'b1, 1'b0, rd_ptr + 1);
        chk("sim_level", 32'(Level_out),      32'd12);
        chk("sim_afull", 32'(AlmostFull_out), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
